// File: rtl/regfile_write_arbiter_if.sv
// Write-back bus between the requesters, the arbiter and the register file.
// The master side drives the requests; the slave side is the arbiter.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int NREQ   = 4
) ();
    logic [NREQ-1:0]        req;
    logic [4*NREQ-1:0]      req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   stall;
    logic [NREQ-1:0]        gnt;
    logic                   wr_valid;
    logic [3:0]             wr_addr;
    logic [15:0]            reg_en;
    logic [DATA_W-1:0]      wr_data;
    logic [1:0]             last_gnt;

    modport master (
        output req, req_addr, req_data, stall,
        input  gnt, wr_valid, wr_addr, reg_en,
        input  wr_data, last_gnt
    );

    modport slave (
        input  req, req_addr, req_data, stall,
        output gnt, wr_valid, wr_addr, reg_en,
        output wr_data, last_gnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// 4-way round-robin write-back arbiter with a registered register-file port.
// Define R0_ZERO_EN to hardwire R0 (writes to address 0 are dropped).
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREQ   = 4
) (
    input logic                    clock,
    input logic                    clear_n,
    regfile_write_arbiter_if.slave bus
);
    logic [1:0]        last_gnt_q, last_gnt_d;
    logic              wr_valid_q, wr_valid_d;
    logic [3:0]        wr_addr_q, wr_addr_d;
    logic [15:0]       reg_en_q, reg_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [3:0]        gnt;
    logic              found;
    logic [1:0]        idx;

    always_comb begin
        gnt        = '0;
        found      = 1'b0;
        idx        = last_gnt_q;
        last_gnt_d = last_gnt_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        // Search starts one past the previous winner and wraps.
        if (clear_n && !bus.stall) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = last_gnt_q + k[1:0];
                if (!found && bus.req[idx]) begin
                    found      = 1'b1;
                    gnt[idx]   = 1'b1;
                    last_gnt_d = idx;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wr_addr_d = bus.req_addr[4*i +: 4];
                wr_data_d = bus.req_data[DATA_W*i +: DATA_W];
            end
        end
`ifdef R0_ZERO_EN
        wr_valid_d = found && (wr_addr_d != 4'd0);
`else
        wr_valid_d = found;
`endif
        reg_en_d = wr_valid_d ? (16'h0001 << wr_addr_d) : 16'h0000;
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            last_gnt_q <= 2'd3;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            reg_en_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            reg_en_q   <= reg_en_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.gnt      = gnt;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.reg_en   = reg_en_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.last_gnt = last_gnt_q;
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, width of write-back data per requester and of wr_data.
REQ-002 Parameter: NREQ, default 4, number of requesters; the only supported value is 4.
REQ-003 Port: clock  in  1  rising-edge clock for all state.
REQ-004 Port: clear_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  4  request from requester i to write one register.
REQ-006 Port: req_addr  in  16  destination register per requester; requester i uses bits [4i+3:4i].
REQ-007 Port: req_data  in  4*DATA_W  write data per requester; requester i uses slice [DATA_W*i +: DATA_W].
REQ-008 Port: stall  in  1  when high, no grant is issued.
REQ-009 Port: gnt  out  4  one-hot grant, combinational, valid in the cycle the request is accepted.
REQ-010 Port: wr_valid  out  1  registered write strobe to the register file.
REQ-011 Port: wr_addr  out  4  registered destination register number.
REQ-012 Port: reg_en  out  16  registered one-hot register enable, decoded from wr_addr.
REQ-013 Port: wr_data  out  DATA_W  registered write data.
REQ-014 Port: last_gnt  out  2  index of the most recently granted requester (round-robin pointer).

Function
REQ-015 Arbitration: round-robin. The search starts at last_gnt+1 and wraps modulo 4. The first requester found with req high wins.
REQ-016 gnt SHALL be nonzero only when stall=0, clear_n=1 and at least one req bit is high. It SHALL never have more than one bit set.
REQ-017 Requester handshake: a requester holds req, req_addr and req_data stable until it sees its gnt bit high. The transfer completes at the rising edge where gnt is high.
REQ-018 Latency: one cycle. Grant at edge N makes wr_valid=1 in cycle N+1, with wr_addr, wr_data and reg_en taken from the winner at edge N.
REQ-019 reg_en SHALL equal 1<<wr_addr while wr_valid=1, and SHALL be all zeros while wr_valid=0.
REQ-020 Any edge without a grant SHALL clear wr_valid and reg_en to 0. wr_addr and wr_data hold their previous values.
REQ-021 last_gnt SHALL update to the winner index on each grant edge and hold otherwise.
REQ-022 Back-to-back: with requests continuously present, a grant issues every cycle. wr_valid stays high across consecutive writes.
REQ-023 A requester that holds req continuously SHALL be granted at least once in every 4 grants (no starvation).
REQ-024 Stall: while stall=1, gnt=0 and last_gnt holds. wr_valid goes to 0 at the next edge. Requesters keep their requests pending.
REQ-025 A stall that falls in the same cycle as requests SHALL block the grant for that cycle only. Arbitration resumes in the following cycle.

Reset
REQ-026 While clear_n=0, asynchronously: wr_valid=0, reg_en=0, wr_addr=0, wr_data=0, last_gnt=3, gnt=0.
REQ-027 After reset release, the first arbitration SHALL favour requester 0.
REQ-028 Reset during an in-flight write SHALL drop that write: wr_valid and reg_en go to 0 immediately. The write is not replayed.

Configuration
REQ-029 Macro R0_ZERO_EN defined: R0 is hardwired to zero.
  - A granted request with address 0 is still granted, advances last_gnt and completes the handshake.
  - In the following cycle it produces wr_valid=0 and reg_en=0.
REQ-030 Macro R0_ZERO_EN undefined: address 0 is written like any other register.

Verification
REQ-031 Reset: clear_n low mid-write with wr_valid=1 -> wr_valid=0 and reg_en=0 before the next clock; last_gnt=3 after reset.
REQ-032 Single request: req=4'b0100, addr=4'd9, data=32'hDEADBEEF, stall=0 -> gnt=4'b0100 same cycle; next cycle wr_valid=1, wr_addr=9, reg_en=16'h0200, wr_data=32'hDEADBEEF.
REQ-033 Fairness: req=4'b1111 held for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; wr_valid=1 for 8 consecutive cycles.
REQ-034 Stall: req=4'b0011, stall=1 for 3 cycles, then 0 -> gnt=0 for 3 cycles; then requester 0 is granted, then requester 1; last_gnt=3 throughout the stall.
REQ-035 R0 write: requester 1 with addr=0, data=32'h5 -> with R0_ZERO_EN, gnt=4'b0010, then wr_valid=0 and reg_en=0; without it, wr_valid=1 and reg_en=16'h0001.
REQ-036 Decode sweep: addresses 0..15 sequentially via requester 3 -> reg_en is one-hot 1<<addr on each write, and all zeros on idle cycles.
